// File: rtl/compress_stream_classifier.sv
// Stream front-end for the compression engine: classifies each packet on its first beat,
// tags every beat (compress/header/runt/oversize) and forwards it through one registered stage.
module compress_stream_classifier #(
  parameter int                    DATA_WIDTH    = 256,
  parameter int                    HDR_BEATS     = 4,
  parameter int                    MAX_PKT_BEATS = 1024,
  parameter logic [DATA_WIDTH-1:0] MATCH_MASK    = 256'h00FF_0000_FFFF_FF00_FFFF_0000_0000_0000,
  parameter logic [DATA_WIDTH-1:0] MATCH_VALUE   = 256'h0006_0000_DC05_2800_0008_0000_0000_0000,
  parameter int                    CNT_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic [3:0]            m_tuser,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  compress_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  localparam logic [15:0]          HDR_LAST = 16'(HDR_BEATS - 1);
  localparam logic [15:0]          HDR_NUM  = 16'(HDR_BEATS);
  localparam logic [15:0]          MAX_IDX  = 16'(MAX_PKT_BEATS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] beat_cnt;
  logic        pkt_compress;
  logic        accept;
  logic        first_beat;
  logic        match;
  logic [15:0] beat_idx;
  logic        beat_runt;
  logic        beat_oversize;
  logic [3:0]  beat_user;

  // Per-beat classification of the beat currently offered at the input.
  assign accept        = s_tvalid & s_tready;
  assign first_beat    = (state == IDLE);
  assign match         = enable & ((s_tdata & MATCH_MASK) == MATCH_VALUE);
  assign beat_idx      = first_beat ? 16'd0 : beat_cnt;
  assign beat_runt     = s_tlast & (beat_idx < HDR_LAST);
  assign beat_oversize = (beat_idx >= MAX_IDX);
  assign beat_user     = {beat_oversize, beat_runt, (beat_idx < HDR_NUM),
                          first_beat ? match : pkt_compress};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        IDLE:    if (!s_tlast) state_nxt = (HDR_LAST == 16'd0) ? DATA : HDR;
        HDR:     if (s_tlast) state_nxt = IDLE;
                 else if (beat_idx >= HDR_LAST) state_nxt = DATA;
        DATA:    if (s_tlast) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    s_tready = !m_tvalid | m_tready;
  end

  // The beat counter holds the index of the next beat; it saturates so very long packets stay oversize.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt     <= 16'd0;
      pkt_compress <= 1'b0;
    end else if (accept) begin
      if (first_beat) pkt_compress <= match;
      if (s_tlast)                 beat_cnt <= 16'd0;
      else if (beat_idx != 16'hFFFF) beat_cnt <= beat_idx + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tuser  <= '0;
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
      m_tlast  <= s_tlast;
      m_tuser  <= beat_user;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  // Statistics are booked when the last beat enters, not when it leaves the output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count      <= '0;
      compress_count <= '0;
      err_count      <= '0;
    end else if (accept && s_tlast) begin
      pkt_count <= pkt_count + CNT_ONE;
      if (beat_user[0])                 compress_count <= compress_count + CNT_ONE;
      if (beat_runt || beat_oversize)   err_count      <= err_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_compress_stream_classifier.sv
// Bench for compress_stream_classifier: directed packets followed by randomized traffic,
// checked every cycle against a packet-level reference model.
module tb_compress_stream_classifier;

  localparam int DW   = 256;
  localparam int HDR  = 4;
  localparam int MAXB = 8;
  localparam int CW   = 32;
  localparam logic [DW-1:0] TB_MASK  = (256'hFF << 184) | (256'hFFFF << 128) |
                                       (256'hFF << 120) | (256'hFFFF << 96);
  localparam logic [DW-1:0] TB_VALUE = (256'h06 << 184) | (256'hDC05 << 128) |
                                       (256'h28 << 120) | (256'h0008 << 96);

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [3:0]    m_tuser;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] compress_count;
  logic [CW-1:0] err_count;
  logic          busy;

  compress_stream_classifier #(
    .DATA_WIDTH(DW), .HDR_BEATS(HDR), .MAX_PKT_BEATS(MAXB),
    .MATCH_MASK(TB_MASK), .MATCH_VALUE(TB_VALUE), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .pkt_count(pkt_count), .compress_count(compress_count),
    .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [3:0]    user;
  } beat_t;

  // Reference model: beats waiting in the output stage plus packet-level bookkeeping.
  beat_t       exp_q[$];
  int          model_pkts;
  int          model_comp;
  int          model_errs;
  bit          in_pkt;
  int          pkt_len;
  bit          pkt_comp;
  bit          accepted;
  int          vectors;
  int          miscompares;
  int          pat_idx;
  logic [3:0]  ready_pat = 4'b1001;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept();
    beat_t b;
    if (!in_pkt) begin
      in_pkt   = 1'b1;
      pkt_len  = 0;
      pkt_comp = enable && ((s_tdata & TB_MASK) == TB_VALUE);
    end
    b.data = s_tdata;
    b.last = s_tlast;
    b.user = {pkt_len >= MAXB, s_tlast && (pkt_len + 1 < HDR), pkt_len < HDR, pkt_comp};
    exp_q.push_back(b);
    pkt_len++;
    if (s_tlast) begin
      model_pkts++;
      if (pkt_comp) model_comp++;
      if (pkt_len < HDR || pkt_len > MAXB) model_errs++;
      in_pkt = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_pkts = 0;
    model_comp = 0;
    model_errs = 0;
    in_pkt     = 1'b0;
  endtask

  task automatic check_output();
    bit exp_valid;
    exp_valid = (exp_q.size() != 0);
    check_val("m_tvalid", m_tvalid, exp_valid);
    check_val("s_tready", s_tready, !exp_valid || m_tready);
    if (exp_valid) begin
      check_val("m_tdata", m_tdata, exp_q[0].data);
      check_val("m_tlast", m_tlast, exp_q[0].last);
      check_val("m_tuser", m_tuser, exp_q[0].user);
    end
    check_val("pkt_count", pkt_count, model_pkts);
    check_val("compress_count", compress_count, model_comp);
    check_val("err_count", err_count, model_errs);
    check_val("busy", busy, in_pkt);
    if (exp_valid && m_tready) void'(exp_q.pop_front());
    accepted = s_tvalid && (!exp_valid || m_tready) && reset;
    if (accepted) model_accept();
  endtask

  task automatic cycle();
    @(negedge clk);
    check_output();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_ready(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 2) begin
      pat_idx++;
      return ready_pat[(pat_idx - 1) % 4];
    end
    return ($urandom % 4) != 0;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic apply_stimulus(input logic [DW-1:0] data, input logic last, input logic en,
                                input int rmode, input bit gaps);
    int tries;
    s_tvalid = 1'b1;
    s_tdata  = data;
    s_tlast  = last;
    enable   = en;
    tries    = 0;
    do begin
      m_tready = pick_ready(rmode);
      cycle();
      tries++;
    end while (!accepted && tries < 64);
    if (!accepted) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL accept_timeout: observed no handshake expected handshake within 64 cycles");
    end
    s_tvalid = 1'b0;
    if (gaps && ($urandom % 3 == 0)) begin
      m_tready = pick_ready(rmode);
      cycle();
    end
  endtask

  task automatic send_packet(input int len, input bit make_match, input logic en,
                             input int rmode, input bit gaps);
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = rand_data();
      if (i == 0) begin
        d = (d & ~TB_MASK) | TB_VALUE;
        if (!make_match) d[191:184] = 8'h11;
      end
      apply_stimulus(d, i == len - 1, (i == 0) ? en : logic'($urandom % 2), rmode, gaps);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    cycle();
    cycle();
  endtask

  initial begin
    logic [DW-1:0] d;
    vectors     = 0;
    miscompares = 0;
    pat_idx     = 0;
    reset       = 1'b0;
    enable      = 1'b0;
    s_tvalid    = 1'b0;
    s_tdata     = '0;
    s_tlast     = 1'b0;
    m_tready    = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    check_val("rst_m_tdata", m_tdata, '0);
    check_val("rst_m_tuser", m_tuser, 4'h0);
    cycle();
    reset = 1'b1;
    $display("[TB] reset released");

    send_packet(6, 1'b1, 1'b1, 0, 1'b0);
    send_packet(6, 1'b0, 1'b1, 0, 1'b0);
    send_packet(6, 1'b1, 1'b0, 0, 1'b0);
    send_packet(8, 1'b1, 1'b1, 2, 1'b0);
    send_packet(2, 1'b1, 1'b1, 0, 1'b0);
    send_packet(5, 1'b1, 1'b1, 0, 1'b0);
    send_packet(10, 1'b1, 1'b1, 1, 1'b1);
    send_packet(1, 1'b0, 1'b1, 0, 1'b0);
    $display("[TB] directed packets done");

    for (int i = 0; i < 3; i++) begin
      d = rand_data();
      if (i == 0) d = (d & ~TB_MASK) | TB_VALUE;
      apply_stimulus(d, 1'b0, 1'b1, 0, 1'b0);
    end
    s_tvalid = 1'b1;
    s_tdata  = rand_data();
    #2;
    reset = 1'b0;
    #1;
    check_val("async_m_tvalid", m_tvalid, 1'b0);
    check_val("async_pkt_count", pkt_count, '0);
    check_val("async_err_count", err_count, '0);
    check_val("async_compress_count", compress_count, '0);
    check_val("async_busy", busy, 1'b0);
    model_reset();
    s_tvalid = 1'b0;
    cycle();
    reset = 1'b1;
    send_packet(5, 1'b1, 1'b1, 0, 1'b0);
    $display("[TB] mid-packet reset done");

    for (int p = 0; p < 40; p++) begin
      send_packet(int'($urandom_range(1, 12)), bit'($urandom % 2), logic'($urandom % 4 != 0),
                  1, 1'b1);
    end
    $display("[TB] random packets done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
